// File: rtl/fp_minmax_reduce_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : fp_minmax_d / fp_minmax_reduce_seq                               |
// | Brief    : Streaming IEEE-754 double FMIN/FMAX reduction over valid/ready. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+

module fp_minmax_d (
    input  logic [63:0] a,
    input  logic [63:0] b,
    input  logic        minmax,
    output logic [63:0] y
);
    localparam logic [63:0] c_qnan = 64'h7FF8000000000000;

    logic w_a_nan;
    logic w_b_nan;
    logic w_a_lt_b;

    assign w_a_nan = (&a[62:52]) & (|a[51:0]);
    assign w_b_nan = (&b[62:52]) & (|b[51:0]);

    // Differing signs: the negative one is smaller, which orders -0 below +0.
    always_comb begin
        if (a[63] != b[63])
            w_a_lt_b = a[63];
        else if (a[63])
            w_a_lt_b = (a[62:0] > b[62:0]);
        else
            w_a_lt_b = (a[62:0] < b[62:0]);
    end

    always_comb begin
        if (w_a_nan && w_b_nan)
            y = c_qnan;
        else if (w_a_nan)
            y = b;
        else if (w_b_nan)
            y = a;
        else if (minmax)
            y = w_a_lt_b ? b : a;
        else
            y = w_a_lt_b ? a : b;
    end
endmodule

module fp_minmax_reduce_seq #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             op_max,
    input  logic [CNT_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    input  logic [63:0]      in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [63:0]      out_data,
    output logic             out_nv,
    input  logic             out_ready
);
    localparam logic [63:0] c_qnan  = 64'h7FF8000000000000;
    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_LOAD  = 2'd1;
    localparam logic [1:0]  S_ACCUM = 2'd2;
    localparam logic [1:0]  S_DONE  = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_next_state;
    logic [63:0]      r_acc;
    logic [CNT_W-1:0] r_remaining;
    logic             r_op;
    logic             r_nv;
    logic [63:0]      w_mm_y;
    logic             w_in_fire;
    logic             w_in_nan;
    logic             w_in_snan;
    logic             w_last;

    assign w_in_fire = in_valid & in_ready;
    assign w_in_nan  = (&in_data[62:52]) & (|in_data[51:0]);
    assign w_in_snan = w_in_nan & ~in_data[51];
    assign w_last    = (r_remaining == CNT_W'(1));

    fp_minmax_d u_minmax (
        .a      (r_acc),
        .b      (in_data),
        .minmax (r_op),
        .y      (w_mm_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = (len == '0) ? S_DONE : S_LOAD;
            S_LOAD:  if (w_in_fire) w_next_state = w_last ? S_DONE : S_ACCUM;
            S_ACCUM: if (w_in_fire && w_last) w_next_state = S_DONE;
            S_DONE:  if (out_ready) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = 64'd0;
        out_nv    = 1'b0;
        case (r_state)
            S_LOAD, S_ACCUM: begin
                busy     = 1'b1;
                in_ready = 1'b1;
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = r_acc;
                out_nv    = r_nv;
            end
            default: ;
        endcase
    end

    // The first element seeds the accumulator; NaNs are canonicalised on entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= 64'd0;
            r_remaining <= '0;
            r_op        <= 1'b0;
            r_nv        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op <= op_max;
                        r_nv <= 1'b0;
                        if (len == '0)
                            r_acc <= c_qnan;
                        else
                            r_remaining <= len;
                    end
                end
                S_LOAD: begin
                    if (w_in_fire) begin
                        r_acc       <= w_in_nan ? c_qnan : in_data;
                        r_remaining <= r_remaining - CNT_W'(1);
                        r_nv        <= r_nv | w_in_snan;
                    end
                end
                S_ACCUM: begin
                    if (w_in_fire) begin
                        r_acc       <= w_mm_y;
                        r_remaining <= r_remaining - CNT_W'(1);
                        r_nv        <= r_nv | w_in_snan;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_fp_minmax_reduce_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_fp_minmax_reduce_seq                                         |
// | Brief    : Directed vector bench for the FMIN/FMAX reduction sequencer.    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+

module tb_fp_minmax_reduce_seq;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             op_max = 1'b0;
    logic [CNT_W-1:0] len = '0;
    logic             busy;
    logic             in_valid = 1'b0;
    logic [63:0]      in_data = 64'd0;
    logic             in_ready;
    logic             out_valid;
    logic [63:0]      out_data;
    logic             out_nv;
    logic             out_ready = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fp_minmax_reduce_seq #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_max    (op_max),
        .len       (len),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_nv    (out_nv),
        .out_ready (out_ready)
    );

    typedef struct {
        logic             op;
        int               n;
        logic [3:0][63:0] d;
        logic [63:0]      exp_data;
        logic             exp_nv;
        int               gap;
        int               hold;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs one job; gap cycles are inserted before each non-first element with
    // a spurious start pulse, and out_ready is held low for hold cycles.
    task automatic run_job(input vec_t v);
        @(negedge clk);
        start  = 1'b1;
        op_max = v.op;
        len    = CNT_W'(v.n);
        @(negedge clk);
        start  = 1'b0;
        for (int i = 0; i < v.n; i++) begin
            if (i > 0) begin
                for (int g = 0; g < v.gap; g++) begin
                    in_valid = 1'b0;
                    start    = 1'b1;
                    op_max   = ~v.op;
                    len      = CNT_W'(0);
                    check("busy_in_gap", 64'(busy), 64'd1);
                    @(negedge clk);
                    start = 1'b0;
                end
            end
            check("in_ready", 64'(in_ready), 64'd1);
            in_valid = 1'b1;
            in_data  = v.d[i];
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = 64'd0;
        check("out_valid_timing", 64'(out_valid), 64'd1);
        check("in_ready_done", 64'(in_ready), 64'd0);
        for (int h = 0; h < v.hold; h++) begin
            start = 1'b1;
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", out_data, v.exp_data);
            check("hold_nv", 64'(out_nv), 64'(v.exp_nv));
            @(negedge clk);
            start = 1'b0;
        end
        check("out_data", out_data, v.exp_data);
        check("out_nv", 64'(out_nv), 64'(v.exp_nv));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_drop", 64'(out_valid), 64'd0);
        check("busy_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        vecs[0] = '{1'b1, 3, {64'd0, 64'h400C000000000000, 64'hC000000000000000, 64'h3FF0000000000000},
                    64'h400C000000000000, 1'b0, 0, 0};
        vecs[1] = '{1'b0, 2, {64'd0, 64'd0, 64'h8000000000000000, 64'h0000000000000000},
                    64'h8000000000000000, 1'b0, 0, 0};
        vecs[2] = '{1'b1, 2, {64'd0, 64'd0, 64'h8000000000000000, 64'h0000000000000000},
                    64'h0000000000000000, 1'b0, 0, 0};
        vecs[3] = '{1'b0, 3, {64'd0, 64'h7FF0000000000001, 64'h4000000000000000, 64'h7FF8000000000000},
                    64'h4000000000000000, 1'b1, 0, 0};
        vecs[4] = '{1'b0, 0, {64'd0, 64'd0, 64'd0, 64'd0},
                    64'h7FF8000000000000, 1'b0, 0, 0};
        vecs[5] = '{1'b1, 2, {64'd0, 64'd0, 64'h7FF4000000000000, 64'h7FF0000000000001},
                    64'h7FF8000000000000, 1'b1, 0, 0};
        // Backpressure: min of {5.0, -1.5, 2.0, -3.0} = -3.0, with gaps and a 5-cycle stall.
        vecs[6] = '{1'b0, 4, {64'hC008000000000000, 64'h4000000000000000, 64'hBFF8000000000000, 64'h4014000000000000},
                    64'hC008000000000000, 1'b0, 2, 5};
        // Back-to-back with a trailing NaN and magnitude ordering among negatives: max = -1.0.
        vecs[7] = '{1'b1, 3, {64'd0, 64'h7FF8000000000000, 64'hBFF0000000000000, 64'hC010000000000000},
                    64'hBFF0000000000000, 1'b0, 0, 0};

        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_nv", 64'(out_nv), 64'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 8; k++) run_job(vecs[k]);

        // Reset mid-ACCUM abandons the job and clears all outputs at once.
        @(negedge clk);
        start  = 1'b1;
        op_max = 1'b0;
        len    = CNT_W'(3);
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 64'h4000000000000000;
        @(negedge clk);
        in_valid = 1'b0;
        check("accum_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd0);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_data", out_data, 64'd0);
        check("midrst_out_nv", 64'(out_nv), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_job('{1'b0, 1, {64'd0, 64'd0, 64'd0, 64'hBFF0000000000000},
                  64'hBFF0000000000000, 1'b0, 0, 0});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
